fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the PC datapath and an external instruction memory, used when the memory is outside the core.
- Holds the fetch PC and issues single-outstanding requests with a valid/ready handshake.
- Buffers returned instructions in a small FIFO toward decode.
- On a redirect (branch, jump or ALU target), flushes the FIFO and discards any in-flight response.

---
 rtl/fetch_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_ctrl
//  Description : Instruction-fetch sequencer with a single outstanding
//                request and an instruction FIFO toward decode.
//                Optional performance counters: FETCH_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter int                  PC_WIDTH          = 32,
    parameter int                  INSTRUCTION_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC          = 32'h0000_0000,
    parameter int                  BUF_DEPTH         = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         redirect_valid,
    input  logic [PC_WIDTH-1:0]          redirect_pc,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [PC_WIDTH-1:0]          imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [INSTRUCTION_WIDTH-1:0] imem_rsp_data,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [INSTRUCTION_WIDTH-1:0] inst_out,
    output logic [PC_WIDTH-1:0]          inst_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                  perf_fetch_cnt,
    output logic [31:0]                  perf_flush_cnt,
    output logic [31:0]                  perf_stall_cnt,
`endif
    output logic [PC_WIDTH-1:0]          inst_pc_plus_4
);

    localparam int                  c_PTR_W   = $clog2(BUF_DEPTH);
    localparam int                  c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_DEPTH   = c_CNT_W'(BUF_DEPTH);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]  c_CNT_ONE = c_CNT_W'(1);
    localparam logic [PC_WIDTH-1:0] c_PC_STEP = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        ST_REQ     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [PC_WIDTH-1:0]            r_fetch_pc;
    logic [PC_WIDTH-1:0]            w_fetch_pc_nxt;
    logic [PC_WIDTH-1:0]            w_redirect_aligned;
    logic [INSTRUCTION_WIDTH-1:0]   r_buf_inst [BUF_DEPTH];
    logic [PC_WIDTH-1:0]            r_buf_pc   [BUF_DEPTH];
    logic [c_PTR_W-1:0]             r_rd_ptr;
    logic [c_PTR_W-1:0]             r_wr_ptr;
    logic [c_CNT_W-1:0]             r_count;
    logic                           w_fifo_full;
    logic                           w_fifo_empty;
    logic                           w_req_fire;
    logic                           w_push;
    logic                           w_pop;
    logic                           w_unused_pc_bits;

    assign w_redirect_aligned = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign w_unused_pc_bits   = ^redirect_pc[1:0];

    assign w_fifo_full  = (r_count == c_DEPTH);
    assign w_fifo_empty = (r_count == '0);
    assign w_req_fire   = imem_req_valid && imem_req_ready;
    // A response arriving in the redirect cycle belongs to the old path.
    assign w_push       = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    assign w_pop        = !w_fifo_empty && inst_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_REQ;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        // Request is held low while reset is asserted, even though state is REQ.
        imem_req_valid = reset && (r_state == ST_REQ) && !w_fifo_full;
        imem_req_addr  = r_fetch_pc;
        case (r_state)
            ST_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = redirect_valid ? ST_DISCARD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = ST_REQ;
                    if (!redirect_valid) begin
                        w_fetch_pc_nxt = r_fetch_pc + c_PC_STEP;
                    end
                end else if (redirect_valid) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (imem_rsp_valid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase
        if (redirect_valid) begin
            w_fetch_pc_nxt = w_redirect_aligned;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: the head is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_inst[r_wr_ptr] <= imem_rsp_data;
            r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
        end
    end

    assign inst_valid     = !w_fifo_empty;
    assign inst_out       = w_fifo_empty ? '0 : r_buf_inst[r_rd_ptr];
    assign inst_pc        = w_fifo_empty ? '0 : r_buf_pc[r_rd_ptr];
    assign inst_pc_plus_4 = w_fifo_empty ? '0 : (r_buf_pc[r_rd_ptr] + c_PC_STEP);

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_push) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end
            if (redirect_valid) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if ((r_state == ST_REQ) && w_fifo_full) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_ctrl
//  Description : Self-checking bench for fetch_ctrl with a memory model and
//                an instruction-stream reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_ctrl;

    localparam int          c_DEPTH  = 2;
    localparam logic [31:0] c_RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus_4;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_flush_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    fetch_ctrl #(
        .PC_WIDTH          (32),
        .INSTRUCTION_WIDTH (32),
        .RESET_PC          (c_RST_PC),
        .BUF_DEPTH         (c_DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_flush_cnt (perf_flush_cnt),
        .perf_stall_cnt (perf_stall_cnt),
`endif
        .inst_pc_plus_4 (inst_pc_plus_4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs
    int rdy_pct = 100;
    int ir_pct  = 100;
    int lat_min = 1;
    int lat_max = 1;
    int redir_pct = 0;

    // Memory model: one outstanding request
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_lat = 0;

    // Reference model: consumed stream and request stream are sequential
    // word addresses restarting at each redirect target.
    logic [31:0] exp_inst_pc = '0;
    logic [31:0] exp_req_addr = '0;
    int          n_hs = 0;
    int          n_consumed = 0;
    int          n_redirects = 0;
    int          cyc_no = 0;
    int          last_hs_cyc = -1;
    bit          chk_gap = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_addr = '0;
    bit          prev_hs = 1'b0;
    bit          saw_wrap = 1'b0;
    bit          want_first = 1'b0;
    logic [31:0] want_pc = '0;

    // Redirect triggers: 1 = same cycle as handshake at trig_addr, 2 = cycle after a handshake
    int          trig_mode = 0;
    logic [31:0] trig_addr = '0;
    logic [31:0] trig_tgt = '0;
    bit          trig_fired = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic cyc(input bit force_redir, input logic [31:0] tgt);
        bit          rdy;
        bit          ir;
        bit          rsp;
        bit          hs;
        bit          redir;
        logic [31:0] target;
        @(negedge clk);
        cyc_no++;
        if (prev_hold) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
                errors++;
                $display("FAIL req_stable got valid=%b addr=%h exp valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
            end
        end
        if (pend) begin
            checks++;
            if (imem_req_valid !== 1'b0) begin
                errors++;
                $display("FAIL single_outstanding got req_valid=%b exp 0", imem_req_valid);
            end
        end
        rsp = 1'b0;
        if (pend) begin
            pend_lat--;
            if (pend_lat == 0) begin
                rsp  = 1'b1;
                pend = 1'b0;
            end
        end
        rdy    = (int'($urandom_range(99)) < rdy_pct);
        ir     = (int'($urandom_range(99)) < ir_pct);
        hs     = imem_req_valid && rdy;
        redir  = force_redir || (int'($urandom_range(99)) < redir_pct);
        target = force_redir ? tgt : $urandom;
        if (trig_mode == 1 && hs && imem_req_addr == trig_addr) begin
            redir = 1'b1; target = trig_tgt; trig_mode = 0; trig_fired = 1'b1;
        end else if (trig_mode == 2 && prev_hs) begin
            redir = 1'b1; target = trig_tgt; trig_mode = 0; trig_fired = 1'b1;
        end
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(pend_addr) : $urandom;
        imem_req_ready = rdy;
        inst_ready     = ir;
        redirect_valid = redir;
        redirect_pc    = redir ? target : $urandom;

        if (inst_valid && ir) begin
            if (want_first) begin
                checks++;
                want_first = 1'b0;
                if (inst_pc !== want_pc) begin
                    errors++;
                    $display("FAIL first_after_redirect got %h exp %h", inst_pc, want_pc);
                end
            end
            checks++;
            if (inst_pc !== exp_inst_pc) begin
                errors++;
                $display("FAIL inst_pc got %h exp %h", inst_pc, exp_inst_pc);
            end
            checks++;
            if (inst_out !== mem_word(exp_inst_pc)) begin
                errors++;
                $display("FAIL inst_out got %h exp %h", inst_out, mem_word(exp_inst_pc));
            end
            checks++;
            if (inst_pc_plus_4 !== exp_inst_pc + 32'd4) begin
                errors++;
                $display("FAIL inst_pc_plus_4 got %h exp %h", inst_pc_plus_4, exp_inst_pc + 32'd4);
            end
            if (exp_inst_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            exp_inst_pc = exp_inst_pc + 32'd4;
            n_consumed++;
        end
        if (hs) begin
            checks++;
            if (imem_req_addr !== exp_req_addr) begin
                errors++;
                $display("FAIL req_addr got %h exp %h", imem_req_addr, exp_req_addr);
            end
            if (chk_gap && last_hs_cyc >= 0) begin
                checks++;
                if (cyc_no - last_hs_cyc != 2) begin
                    errors++;
                    $display("FAIL req_gap got %0d exp 2", cyc_no - last_hs_cyc);
                end
            end
            last_hs_cyc  = cyc_no;
            n_hs++;
            exp_req_addr = exp_req_addr + 32'd4;
            pend         = 1'b1;
            pend_addr    = imem_req_addr;
            pend_lat     = int'($urandom_range(lat_max, lat_min));
        end
        if (redir) begin
            exp_inst_pc  = {target[31:2], 2'b00};
            exp_req_addr = {target[31:2], 2'b00};
            n_redirects++;
        end
        prev_hold = imem_req_valid && !rdy && !redir;
        prev_addr = imem_req_addr;
        prev_hs   = hs;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'h0);
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        redirect_valid = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; inst_ready = 1'b0;
        pend = 1'b0; prev_hold = 1'b0; prev_hs = 1'b0; trig_mode = 0; want_first = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_req_valid got %b exp 0", imem_req_valid);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_inst_valid got %b exp 0", inst_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (imem_req_valid !== 1'b0 || inst_out !== 32'h0 || inst_pc !== 32'h0 || inst_pc_plus_4 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b out=%h pc=%h pc4=%h exp 0 0 0 0", imem_req_valid, inst_out, inst_pc, inst_pc_plus_4);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetch_cnt !== 32'h0 || perf_flush_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_perf got %h %h %h exp 0", perf_fetch_cnt, perf_flush_cnt, perf_stall_cnt);
        end
`endif
        reset = 1'b1;
        exp_inst_pc = c_RST_PC; exp_req_addr = c_RST_PC;
        n_hs = 0; n_redirects = 0; last_hs_cyc = -1;
    endtask

    task automatic test_reset();
        apply_reset();
        rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        run(1);
        checks++;
        if (n_hs != 1) begin
            errors++;
            $display("FAIL first_request got %0d handshakes exp 1", n_hs);
        end
    endtask

    task automatic test_stream();
        int base;
        apply_reset();
        rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1; redir_pct = 0;
        base = n_consumed;
        chk_gap = 1'b1;
        run(24);
        chk_gap = 1'b0;
        checks++;
        if (n_consumed - base < 10) begin
            errors++;
            $display("FAIL stream_throughput got %0d exp >=10", n_consumed - base);
        end
    endtask

    task automatic test_backpressure();
        int base;
        apply_reset();
        rdy_pct = 100; ir_pct = 0; lat_min = 1; lat_max = 1;
        run(12);
        checks++;
        if (n_hs != c_DEPTH) begin
            errors++;
            $display("FAIL bp_requests got %0d exp %0d", n_hs, c_DEPTH);
        end
        @(posedge clk); #1;
        checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== c_RST_PC) begin
            errors++;
            $display("FAIL bp_full got req=%b iv=%b pc=%h exp 0 1 %h", imem_req_valid, inst_valid, inst_pc, c_RST_PC);
        end
        ir_pct = 100;
        base = n_consumed;
        run(12);
        checks++;
        if (n_consumed - base < c_DEPTH + 2) begin
            errors++;
            $display("FAIL bp_drain got %0d exp >=%0d", n_consumed - base, c_DEPTH + 2);
        end
    endtask

    task automatic test_redirect_wait();
        int guard;
        rdy_pct = 100; ir_pct = 100; lat_min = 4; lat_max = 4;
        trig_mode = 2; trig_tgt = 32'h0000_0103; trig_fired = 1'b0;
        guard = 0;
        while (!trig_fired && guard < 50) begin
            cyc(1'b0, 32'h0);
            guard++;
        end
        checks++;
        if (!trig_fired) begin
            errors++;
            $display("FAIL redir_wait_trigger got 0 exp 1");
        end
        want_first = 1'b1; want_pc = 32'h0000_0100;
        run(30);
        checks++;
        if (want_first) begin
            errors++;
            $display("FAIL redir_wait_delivery got none exp %h", want_pc);
        end
    endtask

    task automatic test_redirect_hs();
        int guard;
        apply_reset();
        rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
        trig_mode = 1; trig_addr = 32'h0000_0008; trig_tgt = 32'h0000_0240; trig_fired = 1'b0;
        guard = 0;
        while (!trig_fired && guard < 50) begin
            cyc(1'b0, 32'h0);
            guard++;
        end
        checks++;
        if (!trig_fired) begin
            errors++;
            $display("FAIL redir_hs_trigger got 0 exp 1");
        end
        want_first = 1'b1; want_pc = 32'h0000_0240;
        run(20);
        checks++;
        if (want_first) begin
            errors++;
            $display("FAIL redir_hs_delivery got none exp %h", want_pc);
        end
    endtask

    task automatic test_wrap();
        rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
        saw_wrap = 1'b0;
        cyc(1'b1, 32'hFFFF_FFFE);
        run(16);
        checks++;
        if (!saw_wrap) begin
            errors++;
            $display("FAIL wrap_seen got 0 exp 1");
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        apply_reset();
        rdy_pct = 100; ir_pct = 0; lat_min = 3; lat_max = 3;
        guard = 0;
        while (n_hs < 2 && guard < 50) begin
            cyc(1'b0, 32'h0);
            guard++;
        end
        @(negedge clk);
        checks++;
        if (inst_valid !== 1'b1 || n_hs != 2) begin
            errors++;
            $display("FAIL mid_precondition got iv=%b hs=%0d exp 1 2", inst_valid, n_hs);
        end
        #2;
        apply_reset();
        ir_pct = 100; lat_min = 1; lat_max = 1;
        run(12);
        checks++;
        if (n_hs < 4) begin
            errors++;
            $display("FAIL mid_resume got %0d handshakes exp >=4", n_hs);
        end
    endtask

    task automatic test_random();
        int base;
        rdy_pct = 60; ir_pct = 70; lat_min = 1; lat_max = 5; redir_pct = 3;
        base = n_consumed;
        run(3000);
        redir_pct = 0; rdy_pct = 100; ir_pct = 100; lat_min = 1; lat_max = 1;
        run(20);
        checks++;
        if (n_consumed - base < 200) begin
            errors++;
            $display("FAIL random_progress got %0d exp >=200", n_consumed - base);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_flush_cnt !== 32'(n_redirects)) begin
            errors++;
            $display("FAIL perf_flush got %0d exp %0d", perf_flush_cnt, n_redirects);
        end
`endif
    endtask

    initial begin
        #3;
        test_reset();
        test_stream();
        test_redirect_wait();
        test_backpressure();
        test_redirect_hs();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
